// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with tag allocation, completion writeback,
// operand lookup with same-cycle completion bypass, and one commit per cycle from the head.
module reorder_buffer #(
    parameter int ROB_SIZE = 8,
    parameter int REG_SIZE = 64,
    parameter int GPR_COUNT = 32,
    localparam int TAG_W = $clog2(ROB_SIZE),
    localparam int GPR_IDX_SIZE = $clog2(GPR_COUNT)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_alloc_valid,
    input  logic                    i_alloc_dst_valid,
    input  logic [GPR_IDX_SIZE-1:0] i_alloc_gpr_idx,
    output logic                    o_alloc_ready,
    output logic [TAG_W-1:0]        o_alloc_tag,
    input  logic                    i_cmpl_valid,
    input  logic [TAG_W-1:0]        i_cmpl_tag,
    input  logic [REG_SIZE-1:0]     i_cmpl_value,
    input  logic [TAG_W-1:0]        i_rd0_tag,
    input  logic [TAG_W-1:0]        i_rd1_tag,
    output logic                    o_rd0_done,
    output logic                    o_rd1_done,
    output logic [REG_SIZE-1:0]     o_rd0_value,
    output logic [REG_SIZE-1:0]     o_rd1_value,
    output logic                    o_commit_valid,
    output logic                    o_commit_dst_valid,
    output logic [GPR_IDX_SIZE-1:0] o_commit_gpr_idx,
    output logic [REG_SIZE-1:0]     o_commit_value,
    output logic [TAG_W-1:0]        o_commit_tag,
    output logic [TAG_W:0]          o_count,
    output logic                    o_empty,
    output logic                    o_full
);
    logic [ROB_SIZE-1:0]     valid_q, done_q, dst_q;
    logic [GPR_IDX_SIZE-1:0] gpr_q [ROB_SIZE];
    logic [REG_SIZE-1:0]     value_q [ROB_SIZE];
    logic [TAG_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]          count_q, count_d;
    logic                    alloc_fire, commit, byp0, byp1;

    assign o_count       = count_q;
    assign o_empty       = count_q == '0;
    assign o_full        = count_q == (TAG_W+1)'(ROB_SIZE);
    assign o_alloc_ready = !o_full;
    assign o_alloc_tag   = tail_q;
    assign alloc_fire    = i_alloc_valid && o_alloc_ready;
    assign commit        = valid_q[head_q] && done_q[head_q];

    assign o_commit_valid     = commit;
    assign o_commit_dst_valid = commit && dst_q[head_q];
    assign o_commit_gpr_idx   = commit ? gpr_q[head_q] : '0;
    assign o_commit_value     = commit ? value_q[head_q] : '0;
    assign o_commit_tag       = commit ? head_q : '0;

    // A completion landing this cycle is forwarded straight to the lookup ports.
    assign byp0        = i_cmpl_valid && i_cmpl_tag == i_rd0_tag && valid_q[i_rd0_tag];
    assign byp1        = i_cmpl_valid && i_cmpl_tag == i_rd1_tag && valid_q[i_rd1_tag];
    assign o_rd0_done  = byp0 || (valid_q[i_rd0_tag] && done_q[i_rd0_tag]);
    assign o_rd1_done  = byp1 || (valid_q[i_rd1_tag] && done_q[i_rd1_tag]);
    assign o_rd0_value = byp0 ? i_cmpl_value : o_rd0_done ? value_q[i_rd0_tag] : '0;
    assign o_rd1_value = byp1 ? i_cmpl_value : o_rd1_done ? value_q[i_rd1_tag] : '0;

    always_comb begin
        head_d  = commit ? head_q + 1'b1 : head_q;
        tail_d  = alloc_fire ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (i_cmpl_valid && valid_q[i_cmpl_tag]) begin
                done_q[i_cmpl_tag]  <= 1'b1;
                value_q[i_cmpl_tag] <= i_cmpl_value;
            end
            if (commit)
                valid_q[head_q] <= 1'b0;
            // Head and tail only coincide when empty or full, so alloc never hits the retiring entry.
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                dst_q[tail_q]   <= i_alloc_dst_valid;
                gpr_q[tail_q]   <= i_alloc_gpr_idx;
                value_q[tail_q] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plus short random traffic, checked every cycle against
// a queue-of-tags program-order model, with literal expectations pinning key cycles.
module tb_reorder_buffer;
    logic        clk = 0, rst = 1;
    logic        alloc_v = 0, alloc_dv = 0, cmpl_v = 0;
    logic [4:0]  alloc_gpr = 0;
    logic [2:0]  cmpl_tag = 0, rd0 = 0, rd1 = 0;
    logic [63:0] cmpl_val = 0;
    logic        ready, rd0_done, rd1_done, c_valid, c_dst, empty, full;
    logic [2:0]  alloc_tag, c_tag;
    logic [63:0] rd0_val, rd1_val, c_val;
    logic [4:0]  c_gpr;
    logic [3:0]  count;

    reorder_buffer dut (
        .i_clk(clk), .i_reset(rst),
        .i_alloc_valid(alloc_v), .i_alloc_dst_valid(alloc_dv), .i_alloc_gpr_idx(alloc_gpr),
        .o_alloc_ready(ready), .o_alloc_tag(alloc_tag),
        .i_cmpl_valid(cmpl_v), .i_cmpl_tag(cmpl_tag), .i_cmpl_value(cmpl_val),
        .i_rd0_tag(rd0), .i_rd1_tag(rd1),
        .o_rd0_done(rd0_done), .o_rd1_done(rd1_done),
        .o_rd0_value(rd0_val), .o_rd1_value(rd1_val),
        .o_commit_valid(c_valid), .o_commit_dst_valid(c_dst), .o_commit_gpr_idx(c_gpr),
        .o_commit_value(c_val), .o_commit_tag(c_tag),
        .o_count(count), .o_empty(empty), .o_full(full)
    );

    always #5 clk = ~clk;

    // Model: per-tag records plus a queue of in-flight tags in program order.
    bit          m_valid [8], m_done [8], m_dst [8];
    logic [4:0]  m_gpr [8];
    logic [63:0] m_val [8];
    int          q [$];
    int          nxt = 0;
    int          passed = 0, total = 0;
    bit          chk = 0;

    task automatic ck(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        else passed++;
    endtask

    task automatic look(input string n, input logic [2:0] t, input logic d, input logic [63:0] v);
        bit byp, ed;
        byp = cmpl_v && cmpl_tag == t && m_valid[t];
        ed  = byp || (m_valid[t] && m_done[t]);
        ck({n, "_done"}, 64'(d), 64'(ed));
        ck({n, "_value"}, v, byp ? cmpl_val : ed ? m_val[t] : 64'h0);
    endtask

    task automatic check_all();
        bit cv;
        int h;
        h  = q.size() > 0 ? q[0] : 0;
        cv = q.size() > 0 && m_done[h];
        ck("alloc_ready", 64'(ready), 64'(q.size() < 8));
        ck("alloc_tag", 64'(alloc_tag), 64'(nxt));
        ck("count", 64'(count), 64'(q.size()));
        ck("empty", 64'(empty), 64'(q.size() == 0));
        ck("full", 64'(full), 64'(q.size() == 8));
        ck("commit_valid", 64'(c_valid), 64'(cv));
        ck("commit_dst", 64'(c_dst), 64'(cv && m_dst[h]));
        ck("commit_gpr", 64'(c_gpr), cv ? 64'(m_gpr[h]) : 64'h0);
        ck("commit_value", c_val, cv ? m_val[h] : 64'h0);
        ck("commit_tag", 64'(c_tag), cv ? 64'(h) : 64'h0);
        look("rd0", rd0, rd0_done, rd0_val);
        look("rd1", rd1, rd1_done, rd1_val);
    endtask

    task automatic set_in(input bit a, input int g, input bit c, input int ct, input logic [63:0] cv,
                          input int r0 = 0, input int r1 = 0, input bit dv = 1);
        alloc_v = a; alloc_gpr = 5'(g); alloc_dv = dv;
        cmpl_v = c; cmpl_tag = 3'(ct); cmpl_val = cv;
        rd0 = 3'(r0); rd1 = 3'(r1);
        #1;
        if (chk) check_all();
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic adv();
        bit al, cm;
        @(posedge clk);
        if (rst) begin
            q.delete();
            nxt = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
        end else begin
            al = alloc_v && q.size() < 8;
            cm = q.size() > 0 && m_done[q[0]];
            if (cmpl_v && m_valid[cmpl_tag]) begin
                m_done[cmpl_tag] = 1;
                m_val[cmpl_tag]  = cmpl_val;
            end
            if (cm) begin
                m_valid[q[0]] = 0;
                void'(q.pop_front());
            end
            if (al) begin
                m_valid[nxt] = 1; m_done[nxt] = 0; m_dst[nxt] = alloc_dv;
                m_gpr[nxt] = alloc_gpr; m_val[nxt] = 0;
                q.push_back(nxt);
                nxt = (nxt + 1) % 8;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; idle(); adv(); rst = 0; chk = 1;
    endtask

    initial begin
        @(negedge clk);
        rst = 1; idle(); adv();
        do_reset();
        repeat (3) begin idle(); adv(); end
        idle();
        ck("lit_reset_empty", 64'(empty), 64'h1);
        ck("lit_reset_ready", 64'(ready), 64'h1);
        ck("lit_reset_tag", 64'(alloc_tag), 64'h0);
        ck("lit_reset_commit", 64'(c_valid), 64'h0);
        ck("lit_reset_rd0", 64'(rd0_done), 64'h0);

        // In-order commit despite out-of-order completion.
        set_in(1, 5, 0, 0, 0); adv();
        set_in(1, 6, 0, 0, 0); adv();
        set_in(1, 7, 0, 0, 0); adv();
        set_in(0, 0, 1, 1, 64'h11); adv();
        set_in(0, 0, 1, 0, 64'hAA);
        ck("lit_no_same_cycle_commit", 64'(c_valid), 64'h0);
        adv();
        idle();
        ck("lit_c0_valid", 64'(c_valid), 64'h1);
        ck("lit_c0_tag", 64'(c_tag), 64'h0);
        ck("lit_c0_gpr", 64'(c_gpr), 64'd5);
        ck("lit_c0_value", c_val, 64'hAA);
        adv();
        idle();
        ck("lit_c1_tag", 64'(c_tag), 64'h1);
        ck("lit_c1_gpr", 64'(c_gpr), 64'd6);
        ck("lit_c1_value", c_val, 64'h11);
        adv();
        idle();
        ck("lit_c2_hold", 64'(c_valid), 64'h0);
        ck("lit_c2_count", 64'(count), 64'd1);
        adv();
        set_in(0, 0, 1, 2, 64'h22); adv();
        idle(); adv();

        // Fill, refuse while full (even with head retiring), then wrap.
        do_reset();
        for (int i = 0; i < 8; i++) begin set_in(1, i + 10, 0, 0, 0); adv(); end
        set_in(1, 20, 0, 0, 0);
        ck("lit_full", 64'(full), 64'h1);
        ck("lit_full_ready", 64'(ready), 64'h0);
        adv();
        set_in(1, 20, 1, 0, 64'h100);
        ck("lit_ninth_ignored", 64'(count), 64'd8);
        adv();
        set_in(1, 20, 0, 0, 0);
        ck("lit_full_commit", 64'(c_valid), 64'h1);
        ck("lit_full_no_bypass", 64'(ready), 64'h0);
        adv();
        set_in(1, 9, 0, 0, 0);
        ck("lit_wrap_tag", 64'(alloc_tag), 64'h0);
        adv();
        idle();
        ck("lit_wrap_count", 64'(count), 64'd8);

        // Lookup bypass on port 0, pending tag on port 1.
        set_in(0, 0, 1, 3, 64'h1234, 3, 4);
        ck("lit_byp_done", 64'(rd0_done), 64'h1);
        ck("lit_byp_value", rd0_val, 64'h1234);
        ck("lit_pend_done", 64'(rd1_done), 64'h0);
        ck("lit_pend_value", rd1_val, 64'h0);
        adv();
        set_in(0, 0, 0, 0, 0, 3, 4);
        ck("lit_held_value", rd0_val, 64'h1234);
        adv();

        // Simultaneous alloc and commit at count 4; completion to an unallocated tag.
        do_reset();
        for (int i = 0; i < 4; i++) begin set_in(1, i, 0, 0, 0); adv(); end
        set_in(0, 0, 1, 0, 64'h5); adv();
        set_in(1, 4, 0, 0, 0);
        ck("lit_both_commit", 64'(c_valid), 64'h1);
        adv();
        set_in(0, 0, 1, 6, 64'h66, 6, 5);
        ck("lit_both_count", 64'(count), 64'd4);
        ck("lit_unalloc_nobyp", 64'(rd0_done), 64'h0);
        adv();
        set_in(1, 1, 0, 0, 0); adv();
        set_in(0, 0, 0, 0, 0, 6, 5);
        ck("lit_unalloc_ignored", 64'(rd0_done), 64'h0);
        ck("lit_unalloc_value", rd0_val, 64'h0);
        adv();

        // Reset with five entries in flight, four of them completed behind the head.
        do_reset();
        for (int i = 0; i < 5; i++) begin set_in(1, i, 0, 0, 0); adv(); end
        for (int i = 1; i < 5; i++) begin set_in(0, 0, 1, i, 64'(i * 3)); adv(); end
        do_reset();
        idle();
        ck("lit_rst_count", 64'(count), 64'h0);
        ck("lit_rst_tag", 64'(alloc_tag), 64'h0);
        ck("lit_rst_commit", 64'(c_valid), 64'h0);
        set_in(1, 3, 0, 0, 0, 1); adv();
        set_in(1, 4, 0, 0, 0, 1);
        ck("lit_rst_stale", 64'(rd0_done), 64'h0);
        adv();
        idle();
        ck("lit_rst_no_commit", 64'(c_valid), 64'h0);
        adv();

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            bit c;
            c = q.size() > 0 && ($urandom % 2 == 1);
            set_in($urandom % 2 == 1, int'($urandom % 32), c,
                   c ? q[$urandom % q.size()] : int'($urandom % 8), {$urandom, $urandom},
                   int'($urandom % 8), int'($urandom % 8), $urandom % 4 != 0);
            adv();
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer for the out-of-order core, sitting between dispatch/reservation stations and the architectural register file. Dispatch allocates one entry per cycle and receives a tag; reservation stations read entry state to fill operand `valid`/`value` fields; the completion bus marks entries done with a result; the head entry retires in program order, one per cycle, to the register file.

## Interface

- `ROB_SIZE`, default 8: entry count; power of two, ≥2. `TAG_W = $clog2(ROB_SIZE)`.
- `REG_SIZE`, default 64: result width.
- `GPR_COUNT`, default 32: architectural registers. `GPR_IDX_SIZE = $clog2(GPR_COUNT)`.

- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_alloc_valid`  in  1  dispatch requests an entry.
- `i_alloc_dst_valid`  in  1  instruction writes a GPR.
- `i_alloc_gpr_idx`  in  GPR_IDX_SIZE  destination GPR.
- `o_alloc_ready`  out  1  entry available.
- `o_alloc_tag`  out  TAG_W  tag granted on allocation (tail pointer).
- `i_cmpl_valid`  in  1  completion broadcast.
- `i_cmpl_tag`  in  TAG_W  completing entry.
- `i_cmpl_value`  in  REG_SIZE  result.
- `i_rd0_tag`, `i_rd1_tag`  in  TAG_W  operand lookup tags.
- `o_rd0_done`, `o_rd1_done`  out  1  lookup entry valid and result available.
- `o_rd0_value`, `o_rd1_value`  out  REG_SIZE  result for lookup.
- `o_commit_valid`  out  1  head retires this cycle.
- `o_commit_dst_valid`  out  1  retiring entry writes a GPR.
- `o_commit_gpr_idx`  out  GPR_IDX_SIZE  destination GPR.
- `o_commit_value`  out  REG_SIZE  value to write.
- `o_commit_tag`  out  TAG_W  retiring tag.
- `o_count`  out  TAG_W+1  occupied entries.
- `o_empty`, `o_full`  out  1  count==0 / count==ROB_SIZE.

## Operation

- State: per entry `valid`, `done`, `dst_valid`, `gpr_idx`, `value`; `head`, `tail` (TAG_W, wrap mod ROB_SIZE); `count`.
- Allocate fires when `i_alloc_valid && o_alloc_ready`: entry[tail] ← {valid=1, done=0, dst fields, value=0}; tail+1.
- `o_alloc_ready = (count != ROB_SIZE)`. No bypass of a same-cycle commit: a full buffer refuses allocation even while the head retires.
- Completion: when `i_cmpl_valid` and entry[i_cmpl_tag].valid: done ← 1, value ← i_cmpl_value. Completion to an invalid entry is ignored. Re-completion of a done entry overwrites value.
- Commit (combinational from head): `o_commit_valid = entry[head].valid && entry[head].done`; commit fields driven from entry[head] and forced to 0 when not valid. On commit: entry[head].valid ← 0, head+1. Commit is never back-pressured.
- Lookup port k: if `i_cmpl_valid && i_cmpl_tag == i_rdk_tag` and that entry is valid → done=1, value=i_cmpl_value (bypass). Otherwise done = entry.valid && entry.done, value = entry.value; value is 0 when done=0.
- count: +1 on allocate only, −1 on commit only, unchanged when both or neither.
- Reset: all entries invalid, head=tail=count=0. Reset dominates all inputs in the same cycle.

## Timing

- Reset outputs: o_alloc_ready=1, o_alloc_tag=0, o_commit_valid=0, all commit fields 0, o_rd*_done=0, o_rd*_value=0, o_count=0, o_empty=1, o_full=0.
- Allocate at edge N: entry is visible to lookups and count in cycle N+1.
- Completion at edge N: o_commit_valid rises no earlier than cycle N+1. No same-cycle completion→commit path; lookup bypass is the only same-cycle path.
- Minimum alloc→commit latency: 2 cycles. Throughput: 1 alloc + 1 commit per cycle.
- Wrap-around: tail/head roll from ROB_SIZE−1 to 0; full is detected by count, not pointer equality.
- Reset asserted mid-operation: all in-flight entries are discarded at that edge; no commit is produced in the reset cycle's aftermath.

## Test plan

- Reset, then idle 3 cycles → o_empty=1, o_alloc_ready=1, o_alloc_tag=0, o_commit_valid=0.
- Allocate tags 0,1,2 (gpr 5,6,7); complete tag 1 (0x11), then tag 0 (0xAA) → commit tag0 (gpr5, 0xAA) the cycle after its completion, then tag1 (gpr6, 0x11); tag2 holds until completed.
- Fill 8 entries → o_full=1, o_alloc_ready=0, and a 9th request is ignored. Complete and commit tag 0, allocate → granted tag 0 (wrap); count stays 8.
- Lookup tag 3 while the same tag completes with 0x1234 → o_rd0_done=1 and o_rd0_value=0x1234 in that cycle; the other port on a pending tag → done=0, value=0.
- Allocate and commit in the same cycle at count=4 → count stays 4. Completion to an unallocated tag → no state change.
- 5 entries in flight, assert reset 1 cycle → count=0, head=tail=0, and no commit before new allocations complete.
